fifo_uart_tx: RTL and testbench

Drain side of the byte FIFO: pulls bytes from the FIFO's read port one at a time and serialises each as an asynchronous UART frame (start, 8 data bits LSB first, optional parity, 1 stop) on a single TX line. It sits between the FIFO's empty/read/out_data port and the board TX pin, mirroring the RX path that fills the FIFO.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/fifo_uart_tx.sv | 139 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX drain path and the RX fill path.
// Holds the frame-shape constants and the FSM state encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Even parity over a data byte (1 when the byte has an odd number of ones).
  function automatic logic evenParity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART: counts 0..CLKS_PER_BIT-1 and raises tick for
// one cycle on the last count, wrapping to 0 on the same edge. clr restarts
// the period so a new frame begins on a clean bit boundary.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the bit boundary or on an explicit clear.
  always_comb begin
    tick  = (cnt_q == CW'(CLKS_PER_BIT - 1));
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drain side of the byte FIFO: reads one byte at a time and sends it as a
// UART frame (start, 8 data bits LSB first, optional parity, stop) on tx.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
// CLKS_PER_BIT = CLK_FREQ/BAUD must be at least 2.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic [7:0] fifo_data,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic parity_q, parity_d;
  logic tx_q, tx_d;
  logic rd_q, rd_d;
  logic baudClr;
  logic baudTick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baudClr),
    .tick(baudTick)
  );

  // Next-state logic; tx and fifo_rd are derived from the next state so that
  // their registers line up exactly with the state they belong to.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitIdx_d = bitIdx_q;
    parity_d = parity_q;
    baudClr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d  = fifo_data;
        parity_d = evenParity(fifo_data);
        bitIdx_d = '0;
        baudClr  = 1'b1;
        state_d  = ST_START;
      end
      ST_START: begin
        if (baudTick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baudTick) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bitIdx_q == 3'(DATA_BITS - 1)) begin
            bitIdx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = ST_PARITY;
`else
            state_d  = ST_STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baudTick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baudTick) begin
          if (bitIdx_q == 3'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_d = (state_d == ST_FETCH);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset drops any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitIdx_q <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitIdx_q <= bitIdx_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
    end
  end

  assign tx      = tx_q;
  assign fifo_rd = rd_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a registered-read FIFO model and a
// timeline-based reference: each accepted read defines a frame whose expected
// line level is computed per cycle from its offset to the read strobe.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame shape.
module tb_fifo_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 250_000;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_data;
  logic       tx;
  logic       busy;

  logic [7:0] fifoQ[$];
  int checks = 0;
  int errors = 0;
  int rdCount = 0;
  int cyc = 0;
  bit started = 1'b0;

  bit mActive = 1'b0;
  int mFetch = 0;
  logic [7:0] mByte = 8'h00;
  logic expTx = 1'b1;
  logic expRd = 1'b0;
  logic expBusy = 1'b0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_data (fifo_data),
    .tx        (tx),
    .busy      (busy)
  );

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Line level of bit k of a frame carrying byte b (0 = start bit).
  function automatic logic frameBit(input int k, input logic [7:0] b);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Reference timeline and FIFO model, both advanced on every rising edge.
  always @(posedge clk) begin
    int off;
    cyc++;
    started = 1'b1;
    if (rst) begin
      mActive = 1'b0;
    end else if (mActive && (cyc - mFetch == 2 + FRAME_CYC)) begin
      mActive = 1'b0;
    end else if (!mActive && tx_en && !fifo_empty) begin
      mActive = 1'b1;
      mFetch  = cyc;
      mByte   = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
    end
    if (!mActive) begin
      expTx = 1'b1;
      expRd = 1'b0;
      expBusy = 1'b0;
    end else begin
      off = cyc - mFetch;
      expRd = (off == 0);
      expBusy = 1'b1;
      expTx = (off < 2) ? 1'b1 : frameBit((off - 2) / CPB, mByte);
    end
    if (fifo_rd && fifoQ.size() > 0) begin
      fifo_data <= fifoQ.pop_front();
      rdCount++;
    end
    fifo_empty <= (fifoQ.size() == 0);
  end

  // Compare DUT outputs against the reference in the middle of each cycle.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("tx", tx, expTx);
      checkOutput("fifo_rd", fifo_rd, expRd);
      checkOutput("busy", busy, expBusy);
      checkOutput("rdWhileEmpty", fifo_rd & fifo_empty, 1'b0);
    end
  end

  // Drive reset and tx_enable, then hold them for a number of cycles.
  task automatic applyStimulus(input logic rstV, input logic enV, input int cycles);
    @(negedge clk);
    rst = rstV;
    tx_en = enV;
    repeat (cycles - 1) @(negedge clk);
  endtask

  // Wait for the FIFO to empty and the transmitter to go idle.
  task automatic waitDrain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fifoQ.size() == 0 && !mActive && !busy && fifo_empty) begin
        done = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    checkOutput(tag, done, 1'b1);
  endtask

  // Wait until the read strobe is seen (sampled mid-cycle).
  task automatic waitRead(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fifo_rd) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, seen, 1'b1);
  endtask

  initial begin
    // Reset held with data waiting, then a single 0xA5 frame.
    fifoQ.push_back(8'hA5);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 1);
    waitDrain("drainA5", 200);
    checkOutput("rdCountA5", rdCount, 1);

    // Frame shape with/without parity: 0x07 has odd weight.
    fifoQ.push_back(8'h07);
    waitDrain("drain07", 200);
    checkOutput("rdCount07", rdCount, 2);

    // Three queued bytes back to back.
    fifoQ.push_back(8'h00);
    fifoQ.push_back(8'hFF);
    fifoQ.push_back(8'h3C);
    waitDrain("drain3", 400);
    checkOutput("rdCount3", rdCount, 5);

    // tx_en drops mid-frame: the frame completes, nothing more is read.
    fifoQ.push_back(8'h55);
    fifoQ.push_back(8'h12);
    waitRead("read55", 50);
    repeat (12) @(negedge clk);
    tx_en = 1'b0;
    repeat (FRAME_CYC + 30) @(negedge clk);
    checkOutput("rdCountPaused", rdCount, 6);
    checkOutput("queueHeld", fifoQ.size(), 1);
    tx_en = 1'b1;
    waitDrain("drainResume", 200);
    checkOutput("rdCountResume", rdCount, 7);

    // Reset during data bit 3 drops that byte; the next one goes out cleanly.
    fifoQ.push_back(8'h96);
    fifoQ.push_back(8'h4B);
    waitRead("read96", 50);
    repeat (2 + 4 * CPB - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    waitDrain("drainAfterReset", 300);
    checkOutput("rdCountReset", rdCount, 9);

    // Randomised traffic: pushes, tx_en toggles and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 29) == 0) fifoQ.push_back(8'($urandom));
      if ($urandom_range(0, 89) == 0) tx_en = ~tx_en;
    end
    rst = 1'b0;
    tx_en = 1'b1;
    waitDrain("drainRandom", 20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
